// File: rtl/pkt_stream_arb_pkg.sv
// Shared types, default widths and the round-robin pick helper for pkt_stream_arbiter.
package pkt_stream_arb_pkg;

  localparam int DEF_DATA_WIDTH  = 512;
  localparam int DEF_NUM_IN      = 2;
  localparam int DEF_EMPTY_WIDTH = 6;
  localparam int DEF_CNT_WIDTH   = 16;
  localparam int MAX_IN          = 8;

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First requester at or after rr_ptr, wrapping modulo num_in.
  function automatic pick_t rr_pick(input logic [MAX_IN-1:0] valid_sop,
                                    input logic [2:0]        rr_ptr,
                                    input int                num_in);
    pick_t p;
    int    idx;
    p   = '0;
    idx = 0;
    for (int i = 0; i < MAX_IN; i++) begin
      if (i < num_in) begin
        idx = (int'(rr_ptr) + i) % num_in;
        if (!p.found && valid_sop[idx]) begin
          p.found = 1'b1;
          p.idx   = 3'(idx);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/pkt_stream_skid.sv
// Two-entry Avalon-ST skid buffer; all outputs come straight from registers.
module pkt_stream_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/pkt_stream_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_IN Avalon-ST sources onto one stream.
// Define PKT_STREAM_ARB_OUT_REG_EN to register the merged stream through a 2-entry skid buffer.
module pkt_stream_arbiter
  import pkt_stream_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_IN      = DEF_NUM_IN,
  parameter int EMPTY_WIDTH = DEF_EMPTY_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           in_valid,
  input  logic [NUM_IN-1:0]           in_sop,
  input  logic [NUM_IN-1:0]           in_eop,
  input  logic [NUM_IN-1:0]           in_error,
  input  logic [NUM_IN*EMPTY_WIDTH-1:0] in_empty,
  input  logic [NUM_IN*DATA_WIDTH-1:0]  in_data,
  output logic [NUM_IN-1:0]           in_ready,
  output logic                        out_valid,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic                        out_error,
  output logic [EMPTY_WIDTH-1:0]      out_empty,
  output logic [DATA_WIDTH-1:0]       out_data,
  input  logic                        out_ready,
  output logic [NUM_IN-1:0]           o_grant,
  output logic                        o_busy,
  output logic [NUM_IN*CNT_WIDTH-1:0] o_pkt_cnt,
  output logic                        o_proto_err
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     owner;
  logic [CNT_WIDTH-1:0] pkt_cnt [NUM_IN];

  logic [MAX_IN-1:0]    valid_sop;
  pick_t                pick;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     next_ptr;
  logic                 active;
  logic                 fwd_ready;
  logic                 mux_valid;
  logic                 mux_sop;
  logic                 mux_eop;
  logic                 mux_error;
  logic [EMPTY_WIDTH-1:0] mux_empty;
  logic [DATA_WIDTH-1:0]  mux_data;
  logic                 xfer;
  logic                 err_event;

  // Selection: the locked owner wins outright, otherwise the round-robin candidate.
  always_comb begin
    valid_sop              = '0;
    valid_sop[NUM_IN-1:0]  = in_valid & in_sop;
    pick                   = rr_pick(valid_sop, 3'(rr_ptr), NUM_IN);
    if (state == LOCKED) begin
      sel    = owner;
      active = 1'b1;
    end else begin
      sel    = PTR_W'(pick.idx);
      active = pick.found;
    end
    next_ptr = (int'(sel) == NUM_IN - 1) ? '0 : sel + PTR_W'(1);
  end

  always_comb begin
    o_grant   = '0;
    in_ready  = '0;
    mux_valid = 1'b0;
    mux_sop   = in_sop[sel];
    mux_eop   = in_eop[sel];
    mux_error = in_error[sel];
    mux_empty = in_empty[int'(sel)*EMPTY_WIDTH +: EMPTY_WIDTH];
    mux_data  = in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    if (active) begin
      o_grant[sel]  = 1'b1;
      in_ready[sel] = fwd_ready;
      mux_valid     = in_valid[sel];
    end
  end

  assign xfer      = mux_valid && fwd_ready;
  assign err_event = ((state == IDLE) && |(in_valid & ~in_sop)) ||
                     ((state == LOCKED) && in_valid[owner] && in_sop[owner]);

`ifdef PKT_STREAM_ARB_OUT_REG_EN
  localparam int PW = DATA_WIDTH + EMPTY_WIDTH + 3;
  logic [PW-1:0] skid_out;

  pkt_stream_skid #(.WIDTH(PW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (mux_valid),
    .in_ready  (fwd_ready),
    .in_data   ({mux_sop, mux_eop, mux_error, mux_empty, mux_data}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out)
  );

  assign {out_sop, out_eop, out_error, out_empty, out_data} = skid_out;
`else
  assign fwd_ready = out_ready;
  assign out_valid = mux_valid;
  assign out_sop   = mux_sop;
  assign out_eop   = mux_eop;
  assign out_error = mux_error;
  assign out_empty = mux_empty;
  assign out_data  = mux_data;
`endif

  // Lock FSM; lock, pointer and counters all move on the input-side transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      o_busy      <= 1'b0;
      o_proto_err <= 1'b0;
      for (int i = 0; i < NUM_IN; i++)
        pkt_cnt[i] <= '0;
    end else begin
      if (err_event)
        o_proto_err <= 1'b1;
      if (xfer) begin
        if (mux_eop) begin
          state        <= IDLE;
          o_busy       <= 1'b0;
          rr_ptr       <= next_ptr;
          pkt_cnt[sel] <= pkt_cnt[sel] + CNT_WIDTH'(1);
        end else if (state == IDLE) begin
          state  <= LOCKED;
          o_busy <= 1'b1;
          owner  <= sel;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
    assign o_pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[g];
  end

endmodule

// File: tb/tb_pkt_stream_arbiter.sv
// Directed self-checking bench for pkt_stream_arbiter (two sources, narrow counters for wrap coverage).
module tb_pkt_stream_arbiter;

  localparam int DW = 512;
  localparam int N  = 2;
  localparam int EW = 6;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      in_valid;
  logic [N-1:0]      in_sop;
  logic [N-1:0]      in_eop;
  logic [N-1:0]      in_error;
  logic [N*EW-1:0]   in_empty;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic              out_error;
  logic [EW-1:0]     out_empty;
  logic [DW-1:0]     out_data;
  logic              out_ready;
  logic [N-1:0]      o_grant;
  logic              o_busy;
  logic [N*CW-1:0]   o_pkt_cnt;
  logic              o_proto_err;

  int checkCount = 0;
  int errCount   = 0;

  pkt_stream_arbiter #(
    .DATA_WIDTH(DW), .NUM_IN(N), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_error(in_error),
    .in_empty(in_empty), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_error(out_error),
    .out_empty(out_empty), .out_data(out_data), .out_ready(out_ready),
    .o_grant(o_grant), .o_busy(o_busy), .o_pkt_cnt(o_pkt_cnt), .o_proto_err(o_proto_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int src, input logic v, input logic s, input logic e,
                               input logic [63:0] d);
    in_valid[src]              = v;
    in_sop[src]                = s;
    in_eop[src]                = e;
    in_error[src]              = 1'b0;
    in_empty[src*EW +: EW]     = e ? 6'd3 : 6'd0;
    in_data[src*DW +: DW]      = {{(DW-64){1'b0}}, d};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    applyStimulus(0, 0, 0, 0, 64'h0);
    applyStimulus(1, 0, 0, 0, 64'h0);
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [63:0] cnt(input int src);
    return 64'(o_pkt_cnt[src*CW +: CW]);
  endfunction

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid = '0; in_sop = '0; in_eop = '0; in_error = '0; in_empty = '0; in_data = '0;
    doReset();

    checkOutput("rst_valid", 64'(out_valid), 64'h0);
    checkOutput("rst_ready", 64'(in_ready), 64'h0);
    checkOutput("rst_grant", 64'(o_grant), 64'h0);
    checkOutput("rst_busy", 64'(o_busy), 64'h0);
    checkOutput("rst_cnt", 64'(o_pkt_cnt), 64'h0);
    checkOutput("rst_err", 64'(o_proto_err), 64'h0);

    // Single source, 3-beat packet
    applyStimulus(0, 1, 1, 0, 64'hA1); #1;
    checkOutput("s_grant", 64'(o_grant), 64'h1);
    checkOutput("s_ready", 64'(in_ready), 64'h1);
    checkOutput("s_sop", 64'(out_sop), 64'h1);
    checkOutput("s_data0", out_data[63:0], 64'hA1);
    checkOutput("s_busy0", 64'(o_busy), 64'h0);
    step();
    checkOutput("s_busy1", 64'(o_busy), 64'h1);
    applyStimulus(0, 1, 0, 0, 64'hA2); #1;
    checkOutput("s_data1", out_data[63:0], 64'hA2);
    checkOutput("s_sop1", 64'(out_sop), 64'h0);
    step();
    checkOutput("s_busy2", 64'(o_busy), 64'h1);
    applyStimulus(0, 1, 0, 1, 64'hA3); #1;
    checkOutput("s_data2", out_data[63:0], 64'hA3);
    checkOutput("s_eop", 64'(out_eop), 64'h1);
    checkOutput("s_empty", 64'(out_empty), 64'h3);
    step();
    clearInputs(); #1;
    checkOutput("s_busy3", 64'(o_busy), 64'h0);
    checkOutput("s_cnt0", cnt(0), 64'h1);
    checkOutput("s_cnt1", cnt(1), 64'h0);

    // Single-beat packets from both sources; rr_ptr is 1 so source 1 goes first
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 1, 1, 64'hC0 + 64'(k));
      applyStimulus(1, 1, 1, 1, 64'hD0 + 64'(k));
      #1;
      checkOutput($sformatf("alt_grant%0d", k), 64'(o_grant), (k % 2 == 0) ? 64'h2 : 64'h1);
      checkOutput($sformatf("alt_data%0d", k), out_data[63:0],
                  (k % 2 == 0) ? 64'hD0 + 64'(k) : 64'hC0 + 64'(k));
      step();
      checkOutput($sformatf("alt_busy%0d", k), 64'(o_busy), 64'h0);
    end
    clearInputs(); #1;
    checkOutput("alt_cnt0", cnt(0), 64'h3);
    checkOutput("alt_cnt1", cnt(1), 64'h2);

    // Contention after reset: source 0 first, then source 1 without an idle cycle
    doReset();
    applyStimulus(0, 1, 1, 0, 64'h10);
    applyStimulus(1, 1, 1, 0, 64'h20); #1;
    checkOutput("c_grant0", 64'(o_grant), 64'h1);
    checkOutput("c_data0", out_data[63:0], 64'h10);
    step();
    applyStimulus(0, 1, 0, 1, 64'h11); #1;
    checkOutput("c_ready1", 64'(in_ready), 64'h1);
    checkOutput("c_data1", out_data[63:0], 64'h11);
    step();
    applyStimulus(0, 0, 0, 0, 64'h0); #1;
    checkOutput("c_grant2", 64'(o_grant), 64'h2);
    checkOutput("c_valid2", 64'(out_valid), 64'h1);
    checkOutput("c_data2", out_data[63:0], 64'h20);
    step();
    applyStimulus(1, 1, 0, 1, 64'h21); #1;
    checkOutput("c_data3", out_data[63:0], 64'h21);
    step();
    applyStimulus(0, 1, 1, 1, 64'h12);
    applyStimulus(1, 1, 1, 1, 64'h22); #1;
    checkOutput("c_grant4", 64'(o_grant), 64'h1);
    step();
    clearInputs(); #1;
    checkOutput("c_cnt0", cnt(0), 64'h2);
    checkOutput("c_cnt1", cnt(1), 64'h1);

    // Backpressure on a 4-beat packet from source 1 while source 0 waits
    begin
      int k;
      k = 0;
      for (int c = 0; c < 7; c++) begin
        out_ready = (c % 2 == 0);
        applyStimulus(1, 1, k == 0, k == 3, 64'hB0 + 64'(k));
        applyStimulus(0, 1, 1, 1, 64'h5A);
        #1;
        checkOutput($sformatf("bp_grant%0d", c), 64'(o_grant), 64'h2);
        checkOutput($sformatf("bp_valid%0d", c), 64'(out_valid), 64'h1);
        checkOutput($sformatf("bp_data%0d", c), out_data[63:0], 64'hB0 + 64'(k));
        checkOutput($sformatf("bp_ready%0d", c), 64'(in_ready), {62'b0, out_ready, 1'b0});
        checkOutput($sformatf("bp_busy%0d", c), 64'(o_busy), (c != 0) ? 64'h1 : 64'h0);
        step();
        if (out_ready) k++;
      end
      out_ready = 1'b1;
      applyStimulus(1, 0, 0, 0, 64'h0); #1;
      checkOutput("bp_beats", 64'(k), 64'h4);
      checkOutput("bp_after_grant", 64'(o_grant), 64'h1);
      checkOutput("bp_after_data", out_data[63:0], 64'h5A);
      step();
      clearInputs(); #1;
      checkOutput("bp_cnt0", cnt(0), 64'h3);
      checkOutput("bp_cnt1", cnt(1), 64'h2);
      checkOutput("bp_err", 64'(o_proto_err), 64'h0);
    end

    // Non-sop beat while idle: never granted, flag sticks
    applyStimulus(1, 1, 0, 0, 64'hE1); #1;
    checkOutput("pe_grant", 64'(o_grant), 64'h0);
    checkOutput("pe_valid", 64'(out_valid), 64'h0);
    checkOutput("pe_ready", 64'(in_ready), 64'h0);
    step();
    checkOutput("pe_err1", 64'(o_proto_err), 64'h1);
    applyStimulus(0, 1, 1, 1, 64'hF1); #1;
    checkOutput("pe_grant0", 64'(o_grant), 64'h1);
    checkOutput("pe_data0", out_data[63:0], 64'hF1);
    step();
    clearInputs();
    step();
    checkOutput("pe_cnt0", cnt(0), 64'h4);
    checkOutput("pe_cnt1", cnt(1), 64'h2);
    checkOutput("pe_err2", 64'(o_proto_err), 64'h1);

    // Reset after two beats of a 4-beat packet
    applyStimulus(0, 1, 1, 0, 64'h61); step();
    applyStimulus(0, 1, 0, 0, 64'h62); step();
    checkOutput("rm_busy_pre", 64'(o_busy), 64'h1);
    clearInputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rm_busy", 64'(o_busy), 64'h0);
    checkOutput("rm_cnt", 64'(o_pkt_cnt), 64'h0);
    checkOutput("rm_err", 64'(o_proto_err), 64'h0);
    applyStimulus(1, 1, 1, 0, 64'h71); #1;
    checkOutput("rm_grant", 64'(o_grant), 64'h2);
    checkOutput("rm_data", out_data[63:0], 64'h71);
    step();
    applyStimulus(1, 1, 0, 1, 64'h72); step();
    clearInputs(); #1;
    checkOutput("rm_cnt1", cnt(1), 64'h1);
    checkOutput("rm_cnt0", cnt(0), 64'h0);

    // Counter wrap: sixteen single-beat packets on a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 1, 1, 64'(i));
      step();
      if (i == 14) checkOutput("wrap_max", cnt(0), 64'hF);
    end
    clearInputs(); #1;
    checkOutput("wrap_zero", cnt(0), 64'h0);
    checkOutput("wrap_other", cnt(1), 64'h1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
